// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: shadow/active digit files with frame-aligned commit,
// blank-guarded one-hot digit enables and a registered nibble for the hex decoder.
module display_scan_ctrl #(
    parameter int NDIGITS      = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(NDIGITS)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic                       commit,
    output logic [3:0]                 nibble,
    output logic [NDIGITS-1:0]         an,
    output logic                       frame_tick,
    output logic                       commit_done,
    output logic                       pending
);
    localparam int AW = $clog2(NDIGITS);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_MAX   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [AW-1:0] IDX_MAX   = AW'(NDIGITS - 1);
    localparam logic [AW:0]   NDIG      = (AW + 1)'(NDIGITS);

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [3:0]          shadow_q [NDIGITS];
    logic [3:0]          shadow_d [NDIGITS];
    logic [3:0]          active_q [NDIGITS];
    logic [3:0]          active_d [NDIGITS];
    logic                pending_q, pending_d;
    logic [3:0]          nibble_q, nibble_d;
    logic [NDIGITS-1:0]  an_q, an_d;
    logic                frame_tick_q, frame_tick_d;
    logic                commit_done_q, commit_done_d;
    logic                frame_end;

    always_comb begin
        frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (cnt_d == CNT_BLANK) state_d = ST_DRIVE;
            ST_DRIVE: if (cnt_q == CNT_MAX)   state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        shadow_d = shadow_q;
        if (wr_en && ({1'b0, wr_addr} < NDIG)) shadow_d[wr_addr] = wr_data;

        // The copy takes shadow_q, so a write landing on the frame-end cycle waits for the next commit.
        active_d      = active_q;
        pending_d     = pending_q | commit;
        commit_done_d = 1'b0;
        if (frame_end && (pending_q || commit)) begin
            active_d      = shadow_q;
            pending_d     = 1'b0;
            commit_done_d = 1'b1;
        end

        // Outputs are registered from next-state values so they line up with the counter cycle.
        nibble_d     = active_d[idx_d];
        an_d         = '0;
        if (state_d == ST_DRIVE) an_d = NDIGITS'(1) << idx_d;
        frame_tick_d = (cnt_d == CNT_MAX) && (idx_d == IDX_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            pending_q     <= 1'b0;
            nibble_q      <= '0;
            an_q          <= '0;
            frame_tick_q  <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            nibble_q      <= nibble_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign nibble      = nibble_q;
    assign an          = an_q;
    assign frame_tick  = frame_tick_q;
    assign commit_done = commit_done_q;
    assign pending     = pending_q;
endmodule
